alu_op_sequencer: RTL and testbench

- Initiator side of the ALU interface: takes operation requests over a valid/ready handshake and drives the combinational ALU's operand and opcode inputs.
- Captures the ALU result and N/Z/C/V flags, keeps an architectural NZCV flag register, and predicates each operation on a condition code.
- Returns one response per request over a second valid/ready handshake with backpressure.
- Sits between instruction decode and the alu instance in the RISC datapath.

---
 rtl/alu_op_sequencer_if.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signals of the ALU operation sequencer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; the
// producer holds valid and payload stable until that edge, and ready may depend on state only.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_oper;
    logic [3:0]       req_cond;
    logic             req_setf;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_oper;
    logic [WIDTH-1:0] alu_y;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_exec;
    logic [3:0]       flags;

    modport slave (
        input  req_valid, req_a, req_b, req_oper, req_cond, req_setf,
        output req_ready,
        output alu_a, alu_b, alu_oper,
        input  alu_y, alu_n, alu_z, alu_c, alu_v,
        output rsp_valid, rsp_y, rsp_exec, flags,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_oper, req_cond, req_setf,
        input  req_ready,
        input  alu_a, alu_b, alu_oper,
        output alu_y, alu_n, alu_z, alu_c, alu_v,
        input  rsp_valid, rsp_y, rsp_exec, flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one predicated operation at a time to a combinational ALU, captures its result
// and flags, maintains the architectural NZCV register and returns one response per request.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   oper_q, oper_d;
    logic             pass_q, pass_d;
    logic             setf_q, setf_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             exec_q, exec_d;
    logic [3:0]       flags_q, flags_d;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:    cond_pass = 1'b1;
            4'd1:    cond_pass = z;
            4'd2:    cond_pass = !z;
            4'd3:    cond_pass = n;
            4'd4:    cond_pass = !n;
            4'd5:    cond_pass = v;
            4'd6:    cond_pass = !v;
            4'd7:    cond_pass = c;
            4'd8:    cond_pass = !c;
            4'd9:    cond_pass = (n == v);
            4'd10:   cond_pass = (n != v);
            4'd11:   cond_pass = !z && (n == v);
            4'd12:   cond_pass = z || (n != v);
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            oper_q  <= '0;
            pass_q  <= 1'b0;
            setf_q  <= 1'b0;
            y_q     <= '0;
            exec_q  <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oper_q  <= oper_d;
            pass_q  <= pass_d;
            setf_q  <= setf_d;
            y_q     <= y_d;
            exec_q  <= exec_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        oper_d  = oper_q;
        pass_d  = pass_q;
        setf_d  = setf_q;
        y_d     = y_q;
        exec_d  = exec_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    oper_d  = bus.req_oper;
                    setf_d  = bus.req_setf;
                    // Predicate sees the flags as they stand before this op executes.
                    pass_d  = cond_pass(bus.req_cond, flags_q);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (pass_q) begin
                    y_d    = bus.alu_y;
                    exec_d = 1'b1;
                    if (setf_q) begin
                        flags_d = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
                    end
                end else begin
                    y_d    = '0;
                    exec_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_oper  = oper_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_exec  = exec_q;
    assign bus.flags     = flags_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU stub, a reference model of the flag register
// and predicate table, and a scoreboard queue of {exec, flags, y} expected per response.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    int         checks = 0;
    int         errors = 0;

    logic [W+4:0] exp_q[$];
    logic [3:0]   model_flags;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W), .OPW(4)) bus ();

    alu_op_sequencer #(.WIDTH(W), .OPW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    // Returns {n, z, c, v, y}.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        logic [W:0]   s;
        logic [W-1:0] y;
        logic         c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'd1: begin
                y = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'd2:  y = a & b;
            4'd8:  y = {{(W-1){1'b0}}, a == b};
            4'd10: y = {{(W-1){1'b0}}, $signed(a) <  $signed(b)};
            4'd11: y = {{(W-1){1'b0}}, $signed(a) <= $signed(b)};
            4'd13: y = {{(W-1){1'b0}}, $signed(a) >  $signed(b)};
            default: y = a | b;
        endcase
        alu_fn = {y[W-1], y == '0, c, v, y};
    endfunction

    assign {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_y} =
        alu_fn(bus.alu_a, bus.alu_b, bus.alu_oper);

    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond == 4'd0) return 1'b1;
        if (cond >= 4'd13) return 1'b0;
        case (cond)
            4'd1: return z;          4'd2: return ~z;
            4'd3: return n;          4'd4: return ~n;
            4'd5: return v;          4'd6: return ~v;
            4'd7: return c;          4'd8: return ~c;
            4'd9: return n ~^ v;     4'd10: return n ^ v;
            4'd11: return ~z & (n ~^ v);
            default: return z | (n ^ v);
        endcase
    endfunction

    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                              input logic [3:0] cond, input logic setf);
        logic          pass;
        logic [W+3:0]  r;
        pass = ref_cond(cond, model_flags);
        r    = alu_fn(a, b, op);
        if (pass && setf) model_flags = r[W+3:W];
        exp_q.push_back({pass, model_flags, pass ? r[W-1:0] : {W{1'b0}}});
    endtask

    // Returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic [3:0] cond, input logic setf);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a = a; bus.req_b = b; bus.req_oper = op;
        bus.req_cond = cond; bus.req_setf = setf;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_timeout req_ready stayed 0");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        model_push(a, b, op, cond, setf);
    endtask

    task automatic sb_collect(input string name);
        logic [W+4:0] e;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early rsp_valid=%b want 0", name, bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL %s_latency rsp_valid=%b want 1", name, bus.rsp_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_sb_empty no expected entry", name);
        end else begin
            e = exp_q.pop_front();
            if ({bus.rsp_exec, bus.flags, bus.rsp_y} !== e) begin
                errors++;
                $display("FAIL %s exec=%b flags=%b y=%h want exec=%b flags=%b y=%h", name,
                         bus.rsp_exec, bus.flags, bus.rsp_y, e[W+4], e[W+3:W], e[W-1:0]);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake rsp_valid=%b req_ready=%b want 0 1", name,
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_exec, bus.flags, state} !== 9'b1_0_0_0000_00) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b valid=%b exec=%b flags=%b state=%0d want 1 0 0 0000 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_exec, bus.flags, state);
        end
        checks++;
        if (bus.rsp_y !== '0 || bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_oper !== 4'd0) begin
            errors++;
            $display("FAIL reset_data rsp_y=%h alu_a=%h alu_b=%h alu_oper=%h want all 0",
                     bus.rsp_y, bus.alu_a, bus.alu_b, bus.alu_oper);
        end
        @(negedge clk);
        rst = 1'b0;
        model_flags = 4'b0000;
    endtask

    task automatic test_add_al();
        issue(32'd550, 32'd600, 4'd0, 4'd0, 1'b1);
        checks++;
        if (bus.alu_a !== 32'd550 || bus.alu_b !== 32'd600 || state !== 2'd1) begin
            errors++;
            $display("FAIL add_issue alu_a=%0d alu_b=%0d state=%0d want 550 600 1",
                     bus.alu_a, bus.alu_b, state);
        end
        sb_collect("add_al");
    endtask

    task automatic test_sub_mi();
        issue(32'd2, 32'd3, 4'd1, 4'd0, 1'b1);
        sb_collect("sub_neg");
        issue(32'd3, 32'd3, 4'd2, 4'd3, 1'b1);
        sb_collect("and_mi");
    endtask

    task automatic test_pred_skip();
        issue(32'd3, 32'd3, 4'd8, 4'd1, 1'b1);
        sb_collect("eq_skip");
        issue(32'd3, 32'd3, 4'd1, 4'd0, 1'b1);
        sb_collect("sub_zero");
        issue(32'd3, 32'd3, 4'd8, 4'd1, 1'b1);
        sb_collect("eq_exec");
    endtask

    task automatic test_back_to_back();
        logic [W+4:0] e;
        issue(32'd10, 32'd20, 4'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a = 32'd7; bus.req_b = 32'd9; bus.req_oper = 4'd0;
        bus.req_cond = 4'd0; bus.req_setf = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== e[W-1:0] || bus.rsp_exec !== e[W+4] ||
                bus.req_ready !== 1'b0 || state !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold%0d valid=%b y=%h ready=%b state=%0d want 1 %h 0 2",
                         i, bus.rsp_valid, bus.rsp_y, bus.req_ready, state, e[W-1:0]);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (state !== 2'd0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release state=%0d ready=%b valid=%b want 0 1 0",
                     state, bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || bus.alu_a !== 32'd7) begin
            errors++;
            $display("FAIL bp_second_accept state=%0d alu_a=%0d want 1 7", state, bus.alu_a);
        end
        model_push(32'd7, 32'd9, 4'd0, 4'd0, 1'b1);
        sb_collect("bp_second");
    endtask

    task automatic test_setf0();
        issue(32'd2, 32'd3, 4'd1, 4'd0, 1'b1);
        sb_collect("setf_prep");
        issue(32'hFFFF_FFFB, 32'hFFFF_FFFB, 4'd1, 4'd0, 1'b0);
        sb_collect("setf0");
    endtask

    task automatic test_reset_mid();
        issue(32'd5, 32'd5, 4'd1, 4'd0, 1'b1);
        sb_collect("rm_prep");
        issue(32'd2, 32'd3, 4'd1, 4'd0, 1'b1);
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL rm_exec state=%0d want 1", state);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        model_flags = 4'b0000;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.flags !== 4'b0000 || bus.req_ready !== 1'b1 ||
            bus.rsp_y !== '0) begin
            errors++;
            $display("FAIL rm_after valid=%b flags=%b ready=%b y=%h want 0 0000 1 0",
                     bus.rsp_valid, bus.flags, bus.req_ready, bus.rsp_y);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rm_stale%0d rsp_valid=%b want 0", i, bus.rsp_valid);
            end
        end
        issue(32'd1, 32'd1, 4'd0, 4'd1, 1'b1);
        sb_collect("rm_post_eq");
    endtask

    task automatic test_random_conds();
        logic [3:0] ops[7];
        logic [W-1:0] a, b;
        ops = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd11, 4'd13};
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            issue(a, b, ops[$urandom_range(0, 6)], 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            sb_collect("rand");
        end
    endtask

    initial begin
        rst = 1'b1;
        model_flags = 4'b0000;
        bus.req_valid = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_oper = '0;
        bus.req_cond = '0; bus.req_setf = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add_al();
        test_sub_mi();
        test_pred_skip();
        test_back_to_back();
        test_setf0();
        test_reset_mid();
        test_random_conds();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover entries=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
